// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder: slice width, FSM state type
// and the helper that turns an operand width into a slice count.
package adder_pkg;

   localparam int NIBBLE_W = 32'sd4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int nibbles(input int width);
      return width / NIBBLE_W;
   endfunction

endpackage

// File: rtl/nibble_adder.sv
// Combinational 4-bit ripple-carry slice shared by every nibble position of
// the serial adder.
module nibble_adder
   import adder_pkg::*;
(
   input  logic [NIBBLE_W-1:0] a,
   input  logic [NIBBLE_W-1:0] b,
   input  logic                ci,
   output logic [NIBBLE_W-1:0] s,
   output logic                co
);

   logic [NIBBLE_W:0] total_s;

   // One extra bit on the operands so the slice carry-out lands in the MSB.
   always_comb begin
      total_s = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, ci};
      s       = total_s[NIBBLE_W-1:0];
      co      = total_s[NIBBLE_W];
   end

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder that walks one 4-bit slice per clock with a registered carry.
// Define SIGNED_OVF_EN to add the registered two's-complement overflow output ovf.
module nibble_serial_adder
   import adder_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy
`ifdef SIGNED_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int NIB   = nibbles(WIDTH);
   localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

   generate
      if ((WIDTH < NIBBLE_W) || ((WIDTH % NIBBLE_W) != 0)) begin : g_width_check
         $error("nibble_serial_adder: WIDTH must be a positive multiple of 4");
      end
   endgenerate

   state_t                state_r;
   logic [WIDTH-1:0]      op_a_r;
   logic [WIDTH-1:0]      op_b_r;
   logic [WIDTH-1:0]      sum_r;
   logic                  carry_r;
   logic                  cout_r;
   logic [IDX_W-1:0]      idx_r;
   logic [NIBBLE_W-1:0]   a_nib_s;
   logic [NIBBLE_W-1:0]   b_nib_s;
   logic [NIBBLE_W-1:0]   s_nib_s;
   logic                  co_s;
   logic                  last_s;
`ifdef SIGNED_OVF_EN
   logic                  ovf_r;
`endif

   // AND-OR mux picks the operand nibbles addressed by the slice index.
   always_comb begin
      a_nib_s = {NIBBLE_W{1'b0}};
      b_nib_s = {NIBBLE_W{1'b0}};
      for (int n = 0; n < NIB; n++) begin
         a_nib_s = a_nib_s | (op_a_r[n*NIBBLE_W +: NIBBLE_W] & {NIBBLE_W{idx_r == IDX_W'(n)}});
         b_nib_s = b_nib_s | (op_b_r[n*NIBBLE_W +: NIBBLE_W] & {NIBBLE_W{idx_r == IDX_W'(n)}});
      end
      last_s = (idx_r == LAST_IDX);
   end

   nibble_adder u_slice (
      .a  (a_nib_s),
      .b  (b_nib_s),
      .ci (carry_r),
      .s  (s_nib_s),
      .co (co_s)
   );

   // Control FSM plus the operand, carry, index and result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         op_a_r  <= {WIDTH{1'b0}};
         op_b_r  <= {WIDTH{1'b0}};
         sum_r   <= {WIDTH{1'b0}};
         carry_r <= 1'b0;
         cout_r  <= 1'b0;
         idx_r   <= {IDX_W{1'b0}};
`ifdef SIGNED_OVF_EN
         ovf_r   <= 1'b0;
`endif
      end else begin
         case (state_r)
            IDLE: begin
               if (in_valid) begin
                  op_a_r  <= op_a;
                  op_b_r  <= op_b;
                  carry_r <= cin;
                  sum_r   <= {WIDTH{1'b0}};
                  idx_r   <= {IDX_W{1'b0}};
                  state_r <= RUN;
               end
            end
            RUN: begin
               for (int n = 0; n < NIB; n++) begin
                  if (idx_r == IDX_W'(n)) begin
                     sum_r[n*NIBBLE_W +: NIBBLE_W] <= s_nib_s;
                  end
               end
               carry_r <= co_s;
               if (last_s) begin
                  cout_r  <= co_s;
`ifdef SIGNED_OVF_EN
                  // Carry into the top bit is recovered from its sum bit.
                  ovf_r   <= co_s ^ (a_nib_s[NIBBLE_W-1] ^ b_nib_s[NIBBLE_W-1] ^ s_nib_s[NIBBLE_W-1]);
`endif
                  idx_r   <= {IDX_W{1'b0}};
                  state_r <= DONE;
               end else begin
                  idx_r   <= idx_r + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_r <= IDLE;
               end
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign in_ready  = (state_r == IDLE);
   assign busy      = (state_r != IDLE);
   assign out_valid = (state_r == DONE);
   assign sum       = sum_r;
   assign cout      = cout_r;
`ifdef SIGNED_OVF_EN
   assign ovf       = ovf_r;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder (WIDTH=16) driven by directed vectors.
module tb_nibble_serial_adder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        cin = 1'b0;
   logic        out_ready = 1'b1;
   logic [15:0] op_a = 16'h0000;
   logic [15:0] op_b = 16'h0000;
   logic        in_ready;
   logic        out_valid;
   logic        cout;
   logic        busy;
   logic [15:0] sum;
`ifdef SIGNED_OVF_EN
   logic        ovf;
`endif

   typedef struct {
      logic [15:0] s;
      logic        c;
      logic        o;
      int          acc;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   n_pass = 0;
   int   n_total = 0;
   bit   seen = 1'b0;

   always #5 clk = ~clk;

   nibble_serial_adder #(.WIDTH(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op_a      (op_a),
      .op_b      (op_b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .busy      (busy)
`ifdef SIGNED_OVF_EN
      ,
      .ovf       (ovf)
`endif
   );

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Output monitor: compares whatever the DUT presents against the queue head.
   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         if (q.size() == 0) begin
            chk("unexpected_out_valid", 32'd1, 32'd0);
         end else begin
            if (!seen) begin
               chk("latency", cyc - q[0].acc, 32'd4);
               seen = 1'b1;
            end
            chk("sum", {16'h0000, sum}, {16'h0000, q[0].s});
            chk("cout", {31'd0, cout}, {31'd0, q[0].c});
`ifdef SIGNED_OVF_EN
            chk("ovf", {31'd0, ovf}, {31'd0, q[0].o});
`endif
            if (out_ready) begin
               void'(q.pop_front());
               seen = 1'b0;
            end
         end
      end
   end

   task automatic send(input logic [15:0] a, input logic [15:0] b, input logic c,
                       input logic [15:0] es, input logic ec, input logic eo,
                       input bit push, input bit keep);
      bit ok;
      ok = 1'b0;
      op_a = a; op_b = b; cin = c; in_valid = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            if (push) q.push_back('{es, ec, eo, cyc + 1});
            break;
         end
      end
      if (!ok) chk("accept_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      if (!keep) begin
         in_valid = 1'b0; op_a = ~a; op_b = a ^ 16'h5A5A; cin = ~c;
      end
   endtask

   task automatic drain();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (q.size() == 0) begin ok = 1'b1; break; end
      end
      if (!ok) chk("drain_timeout", q.size(), 32'd0);
      repeat (8) @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_sum", {16'h0000, sum}, 32'd0);
      chk("rst_cout", {31'd0, cout}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // 1: plain add
      send(16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b1, 1'b0);
      drain();
      // 2: carry ripples through every nibble
      send(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
      drain();

      // 3: backpressure with an ignored in_valid pulse
      out_ready = 1'b0;
      send(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (out_valid) break;
      end
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b1; op_a = 16'h1111; op_b = 16'h2222;
      @(negedge clk);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_busy", {31'd0, busy}, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("bp_in_ready2", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("post_hs_in_ready", {31'd0, in_ready}, 32'd1);
      chk("post_hs_out_valid", {31'd0, out_valid}, 32'd0);
      drain();

      // 4: reset during the second RUN cycle
      send(16'hAAAA, 16'h5555, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("abort_sum", {16'h0000, sum}, 32'd0);
      chk("abort_cout", {31'd0, cout}, 32'd0);
      chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
      chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      drain();

      // 5: back-to-back with in_valid held high
      send(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1);
      send(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1, 1'b0);
      drain();

      // 6: operands churn during RUN
      send(16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) begin
         op_a = 16'h1357 + 16'(i * 16'h1111); op_b = 16'hFEDC - 16'(i); cin = i[0];
         @(posedge clk); #1;
      end
      drain();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
